// File: rtl/laser_link_scheduler.sv
// Frame sequencer feeding a dual-lane laser transmitter: preamble, header, payload,
// per-lane XOR checksum and an inter-frame gap, one byte pair per lane_done handshake.
`timescale 1ns / 1ps

module laser_link_scheduler #(
  parameter int unsigned PREAMBLE_LEN = 2,
  parameter logic [7:0]  SYNC_BYTE    = 8'h7E,
  parameter int unsigned IDLE_GAP     = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        start,
  input  logic [7:0]  frame_len,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [7:0]  lane1_data,
  output logic [7:0]  lane2_data,
  output logic        lane_ready,
  input  logic        lane_done,
  output logic        busy,
  output logic        frame_done,
  output logic        abort,
  output logic        underrun
);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StHeader,
    StPayload,
    StChecksum,
    StGap
  } state_e;

  localparam logic [7:0] PreLast = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GapLast = 8'(IDLE_GAP - 1);

  state_e     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_len;
  logic [7:0] r_xor1;
  logic [7:0] r_xor2;
  logic [7:0] r_lane1;
  logic [7:0] r_lane2;
  logic       r_lane_ready;
  logic       r_first;
  logic       r_busy;
  logic       r_frame_done;
  logic       r_abort;
  logic       r_underrun;

  logic       w_src_ready;
  logic       w_load;
  logic       w_done;
  logic [7:0] w_cnt_inc;

  // In PAYLOAD the lane data registers are the pair register; lane_ready marks it loaded.
  assign w_src_ready = (r_state == StPayload) && !r_lane_ready;
  assign w_load      = w_src_ready && src_valid;
  assign w_done      = lane_done && r_lane_ready;
  assign w_cnt_inc   = r_cnt + 8'd1;

  assign src_ready  = w_src_ready;
  assign lane1_data = r_lane1;
  assign lane2_data = r_lane2;
  assign lane_ready = r_lane_ready;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign abort      = r_abort;
  assign underrun   = r_underrun;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_cnt        <= 8'h00;
      r_len        <= 8'h00;
      r_xor1       <= 8'h00;
      r_xor2       <= 8'h00;
      r_lane1      <= 8'h00;
      r_lane2      <= 8'h00;
      r_lane_ready <= 1'b0;
      r_first      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_abort      <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_abort      <= 1'b0;
      if (r_state != StIdle && !en) begin
        r_state      <= StIdle;
        r_cnt        <= 8'h00;
        r_lane1      <= 8'h00;
        r_lane2      <= 8'h00;
        r_lane_ready <= 1'b0;
        r_first      <= 1'b0;
        r_busy       <= 1'b0;
        r_abort      <= 1'b1;
      end else begin
        case (r_state)
          StIdle: begin
            if (start && en && frame_len != 8'h00) begin
              r_state      <= StPreamble;
              r_len        <= frame_len;
              r_cnt        <= 8'h00;
              r_xor1       <= 8'h00;
              r_xor2       <= 8'h00;
              r_underrun   <= 1'b0;
              r_busy       <= 1'b1;
              r_lane_ready <= 1'b1;
              r_lane1      <= 8'h55;
              r_lane2      <= 8'h55;
            end
          end
          StPreamble: begin
            if (w_done) begin
              if (r_cnt == PreLast) begin
                r_state <= StHeader;
                r_cnt   <= 8'h00;
                r_lane1 <= SYNC_BYTE;
                r_lane2 <= r_len;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
          StHeader: begin
            if (w_done) begin
              r_state      <= StPayload;
              r_lane_ready <= 1'b0;
              r_lane1      <= 8'h00;
              r_lane2      <= 8'h00;
              r_first      <= 1'b1;
            end
          end
          StPayload: begin
            if (w_done) begin
              r_cnt   <= w_cnt_inc;
              r_first <= 1'b1;
              if (w_cnt_inc == r_len) begin
                r_state <= StChecksum;
                r_lane1 <= r_xor1;
                r_lane2 <= r_xor2;
              end else begin
                r_lane_ready <= 1'b0;
                r_lane1      <= 8'h00;
                r_lane2      <= 8'h00;
              end
            end else if (w_load) begin
              r_lane_ready <= 1'b1;
              r_lane1      <= src_data[15:8];
              r_lane2      <= src_data[7:0];
              r_xor1       <= r_xor1 ^ src_data[15:8];
              r_xor2       <= r_xor2 ^ src_data[7:0];
              r_first      <= 1'b0;
            end else if (w_src_ready) begin
              // The first fetch cycle after a handshake is grace, not a stall.
              if (!r_first) r_underrun <= 1'b1;
              r_first <= 1'b0;
            end
          end
          StChecksum: begin
            if (w_done) begin
              r_state      <= StGap;
              r_cnt        <= 8'h00;
              r_lane_ready <= 1'b0;
              r_lane1      <= 8'h00;
              r_lane2      <= 8'h00;
            end
          end
          StGap: begin
            if (r_cnt == GapLast) begin
              r_state      <= StIdle;
              r_cnt        <= 8'h00;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_laser_link_scheduler.sv
// Directed bench for laser_link_scheduler: table of frame scenarios driven through a
// transmitter/source model, plus hand sequences for abort, reset and illegal starts.
`timescale 1ns / 1ps

module tb_laser_link_scheduler;

  localparam int unsigned PreLen = 2;
  localparam logic [7:0]  Sync   = 8'h7E;
  localparam int unsigned Gap    = 16;

  logic        clock;
  logic        reset_n;
  logic        en;
  logic        start;
  logic [7:0]  frame_len;
  logic [15:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  lane1_data;
  logic [7:0]  lane2_data;
  logic        lane_ready;
  logic        lane_done;
  logic        busy;
  logic        frame_done;
  logic        abort;
  logic        underrun;

  laser_link_scheduler #(
    .PREAMBLE_LEN(PreLen),
    .SYNC_BYTE   (Sync),
    .IDLE_GAP    (Gap)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .start     (start),
    .frame_len (frame_len),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .lane1_data(lane1_data),
    .lane2_data(lane2_data),
    .lane_ready(lane_ready),
    .lane_done (lane_done),
    .busy      (busy),
    .frame_done(frame_done),
    .abort     (abort),
    .underrun  (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  len;
    logic [15:0] p0;
    logic [15:0] p1;
    int          stall;  // cycles src_valid is held low before the second pair
    bit          poke;   // pulse start (frame_len 9) while the frame is busy
    bit          bdone;  // pulse lane_done inside the first payload bubble
    bit          gen;    // payload word i = {i, ~i}
    logic [15:0] ck;
    bit          und;
  } vec_t;

  vec_t        vecs[6];
  int          total;
  int          bad;
  logic [15:0] words[256];
  int          src_n;
  int          src_idx;
  int          stall_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic update_src();
    if (src_idx == 1 && stall_left > 0) begin
      src_valid = 1'b0;
      stall_left--;
    end else begin
      src_valid = (src_idx < src_n);
    end
    src_data = (src_idx < src_n) ? words[src_idx] : 16'h0000;
  endtask

  task automatic load_src(input vec_t v);
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      if (v.gen)       words[i] = {b, ~b};
      else if (i == 0) words[i] = v.p0;
      else if (i == 1) words[i] = v.p1;
      else             words[i] = 16'h0000;
    end
    src_n      = int'(v.len);
    src_idx    = 0;
    stall_left = v.stall;
    update_src();
  endtask

  // One clock: inputs change and outputs are sampled only at the falling edge.
  task automatic tick();
    bit acc;
    acc = src_valid && src_ready;
    @(posedge clock);
    @(negedge clock);
    lane_done = 1'b0;
    if (acc) src_idx++;
    update_src();
  endtask

  // mode 0: pair must already be presented; 1: at least one bubble cycle first.
  task automatic xmit(input logic [15:0] exp, input int mode, input bit poke, input string tag);
    int waits;
    waits = 0;
    while (!lane_ready && waits < 50) begin
      tick();
      waits++;
    end
    check({tag, " present"}, {lane_ready, lane1_data, lane2_data}, {1'b1, exp});
    if (mode == 0) check({tag, " no bubble"}, waits, 0);
    else           check({tag, " bubble"}, waits >= 1, 1);
    if (poke) begin
      start     = 1'b1;
      frame_len = 8'd9;
    end
    tick();
    start = 1'b0;
    if (poke) check("busy start ignored", {busy, lane_ready, lane1_data, lane2_data},
                    {1'b1, 1'b1, exp});
    tick();
    check({tag, " hold"}, {lane_ready, lane1_data, lane2_data}, {1'b1, exp});
    lane_done = 1'b1;
    tick();
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int n;
    load_src(v);
    frame_len = v.len;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " start"}, {busy, underrun}, 2'b10);
    for (int i = 0; i < int'(PreLen); i++) xmit(16'h5555, 0, v.poke && i == 0, {tag, " pre"});
    xmit({Sync, v.len}, 0, 1'b0, {tag, " hdr"});
    for (int i = 0; i < int'(v.len); i++) begin
      xmit(words[i], (v.bdone && i == 1) ? 0 : 1, 1'b0, {tag, " pay"});
      if (v.bdone && i == 0) begin
        check({tag, " bubble low"}, lane_ready, 1'b0);
        lane_done = 1'b1;
        tick();
      end
    end
    xmit(v.ck, 0, 1'b0, {tag, " ck"});
    check({tag, " gap idle lanes"}, {lane_ready, lane1_data, lane2_data, busy}, {17'h0, 1'b1});
    n = 0;
    while (!frame_done && n < 40) begin
      tick();
      n++;
    end
    check({tag, " gap len"}, n, Gap);
    check({tag, " end busy"}, busy, 1'b0);
    check({tag, " underrun"}, underrun, v.und);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    vecs[0] = '{8'd2,   16'h0817, 16'hAA55, 0,  1'b0, 1'b0, 1'b0, 16'hA242, 1'b0};
    vecs[1] = '{8'd2,   16'h0817, 16'hAA55, 10, 1'b0, 1'b0, 1'b0, 16'hA242, 1'b1};
    vecs[2] = '{8'd1,   16'h1234, 16'h0000, 0,  1'b0, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[3] = '{8'd2,   16'hFFFF, 16'h0F0F, 0,  1'b1, 1'b0, 1'b0, 16'hF0F0, 1'b0};
    vecs[4] = '{8'd2,   16'hC3A5, 16'h5A3C, 0,  1'b0, 1'b1, 1'b0, 16'h9999, 1'b0};
    vecs[5] = '{8'd255, 16'h0000, 16'h0000, 0,  1'b0, 1'b0, 1'b1, 16'hFF00, 1'b0};

    reset_n    = 1'b0;
    en         = 1'b1;
    start      = 1'b0;
    frame_len  = 8'd0;
    lane_done  = 1'b0;
    src_n      = 0;
    src_idx    = 0;
    stall_left = 0;
    update_src();
    repeat (2) @(negedge clock);
    check("reset outputs", {lane_ready, src_ready, busy, frame_done, abort, underrun,
                            lane1_data, lane2_data}, 22'h0);
    reset_n = 1'b1;
    tick();
    check("idle outputs", {lane_ready, src_ready, busy, lane1_data, lane2_data}, 19'h0);

    for (int k = 0; k < 6; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

    // frame_len = 0 is not a legal start
    frame_len = 8'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("len0 ignored", {busy, lane_ready, lane1_data, lane2_data}, 18'h0);
    tick();
    check("len0 still idle", {busy, lane_ready}, 2'b00);

    // en dropped while the second payload pair is on the lanes
    load_src(vecs[0]);
    frame_len = 8'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    xmit(16'h5555, 0, 1'b0, "ab pre");
    xmit(16'h5555, 0, 1'b0, "ab pre");
    xmit({Sync, 8'd2}, 0, 1'b0, "ab hdr");
    xmit(16'h0817, 1, 1'b0, "ab pay");
    n = 0;
    while (!lane_ready && n < 50) begin
      tick();
      n++;
    end
    check("ab second pair", {lane_ready, lane1_data, lane2_data}, {1'b1, 16'hAA55});
    en = 1'b0;
    tick();
    check("abort edge", {lane_ready, busy, abort, src_ready, lane1_data, lane2_data},
          {4'b0010, 16'h0});
    tick();
    check("abort one pulse", {abort, busy}, 2'b00);
    en = 1'b1;
    n  = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (frame_done) n++;
    end
    check("abort no frame_done", n, 0);
    run_frame(vecs[2], "post abort");

    // asynchronous reset while the header pair is presented
    load_src(vecs[0]);
    frame_len = 8'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    xmit(16'h5555, 0, 1'b0, "rst pre");
    xmit(16'h5555, 0, 1'b0, "rst pre");
    check("rst in header", {lane_ready, lane1_data, lane2_data}, {1'b1, Sync, 8'd2});
    #2 reset_n = 1'b0;
    #1;
    check("async reset", {lane_ready, src_ready, busy, frame_done, abort, underrun,
                          lane1_data, lane2_data}, 22'h0);
    @(negedge clock);
    reset_n = 1'b1;
    run_frame(vecs[0], "post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/laser_link_scheduler.md
# laser_link_scheduler

Frame sequencer that sits between the host byte source and the dual-lane laser transmitter. It wraps a burst of byte pairs into a framed transmission: preamble, header, payload and per-lane XOR checksum, followed by an inter-frame gap. It drives the transmitter's data/ready inputs one pair at a time and advances on the transmitter's completion pulse. It also handles stalls, aborts and status reporting for the link.

## Interface
Parameters:
- PREAMBLE_LEN, 2: number of preamble pairs {8'h55, 8'h55}; legal range 1–15.
- SYNC_BYTE, 8'h7E: lane-1 header byte.
- IDLE_GAP, 16: number of clock cycles in GAP; legal range 1–255.

Ports:
- clock  in  1  single system clock; all logic is on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  link enable; low aborts any frame.
- start  in  1  request a frame; sampled only in IDLE.
- frame_len  in  8  payload pair count; sampled with start; 0 is illegal.
- src_data  in  16  payload pair; [15:8] goes to lane 1, [7:0] to lane 2.
- src_valid  in  1  src_data is valid.
- src_ready  out  1  scheduler accepts a pair this cycle.
- lane1_data  out  8  byte presented to transmitter lane 1.
- lane2_data  out  8  byte presented to transmitter lane 2.
- lane_ready  out  1  pair on lane1/2_data is valid; drives data_ready1/2.
- lane_done  in  1  single-cycle pulse (synchronous to clock) when the transmitter has consumed the presented pair.
- busy  out  1  high from accepted start until return to IDLE.
- frame_done  out  1  one-cycle pulse on normal completion.
- abort  out  1  one-cycle pulse when en drops mid-frame.
- underrun  out  1  sticky; set on any payload stall; cleared on the next accepted start.

## Operation
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, CHECKSUM, GAP.
- IDLE:
  - start && en && frame_len != 0 → PREAMBLE.
  - On that transition: latch frame_len; clear pair counter, both checksums and underrun.
  - start under any other condition is ignored.
- PREAMBLE: presents {8'h55, 8'h55}; after PREAMBLE_LEN lane_done pulses → HEADER.
- HEADER: presents {SYNC_BYTE, latched frame_len}; on lane_done → PAYLOAD.
- PAYLOAD:
  - src_ready = (state == PAYLOAD) && !pair_loaded (combinational).
  - src_valid && src_ready loads the pair register and sets pair_loaded.
  - Each loaded byte is XORed into its lane checksum.
  - lane_ready = pair_loaded.
  - On lane_done: clear pair_loaded and increment the counter. When the count reaches the latched frame_len → CHECKSUM.
- Stall: src_ready high with src_valid low in PAYLOAD sets underrun. Does not apply on the first fetch cycle after HEADER or after a lane_done.
- CHECKSUM: presents {xor1, xor2}; on lane_done → GAP.
- GAP:
  - lane_ready = 0; count IDLE_GAP cycles, then → IDLE.
  - frame_done pulses in the cycle the state becomes IDLE.
- In PREAMBLE, HEADER and CHECKSUM, lane_ready = 1 continuously.
- Data outputs hold stable while lane_ready = 1 until lane_done.
- lane_done while lane_ready = 0 is ignored.
- en low in any non-IDLE state:
  - Next edge → IDLE with lane_ready = 0 and busy = 0.
  - abort pulses for one cycle.
  - Pair register is discarded; no frame_done.
- lane1/2_data read 8'h00 whenever lane_ready = 0.

## Timing
- Reset values: state IDLE; lane1_data = lane2_data = 8'h00; lane_ready, src_ready, busy, frame_done, abort and underrun all 0; counters and checksums 0.
- reset_n low takes effect immediately (asynchronous), including mid-frame.
- Start accepted at edge k: busy = 1 and lane_ready = 1 with the preamble pair from cycle k+1.
- lane_done at edge j in PREAMBLE or HEADER: the next pair is presented at j+1, with no bubble.
- PAYLOAD fetch:
  - src_ready is high in cycle j+1; with src_valid the pair is loaded at that edge.
  - lane_ready rises at j+2, so there is a minimum one-cycle bubble per payload pair.
- Last payload lane_done at edge j: checksum pair presented at j+1; the checksum includes every accepted pair.
- GAP entered at edge g: IDLE plus frame_done at edge g + IDLE_GAP; busy falls the same cycle.
- A start in the frame_done cycle is accepted, since the state is IDLE.
- Counter width is 8 bits; frame_len = 255 produces 255 payload pairs with no wrap.

## Test plan
- frame_len = 2; src pairs 16'h0817, 16'hAA55; lane_done 3 cycles after each lane_ready rise → pair sequence 5555, 5555, 7E02, 0817, AA55, A242; frame_done 16 cycles after entering GAP; underrun = 0.
- Same frame with src_valid held low for 10 cycles before the second pair → lane_ready low during the stall; underrun = 1; checksum still A242; frame completes.
- en dropped during the second PAYLOAD pair → next edge: state IDLE, lane_ready = 0, busy = 0, abort pulses once, no frame_done; a later start with frame_len = 1 runs a full frame.
- start with frame_len = 0, and start while busy → ignored: busy, lane_ready and the sequence are unchanged.
- reset_n asserted mid-HEADER → all outputs 0 in the same cycle, without waiting for a clock edge; after release, a start works normally.
- lane_done pulsed during a payload bubble (lane_ready = 0) → ignored, counter unchanged; frame_len = 255 → exactly 255 payload pairs, then checksum.
